dtw_ctrl: RTL

DTW_CTRL -- requirements
Module: dtw_ctrl

---
 rtl/dtw_pkg.sv | 16 +
 rtl/dtw_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW systolic-array controller: select encodings and FSM states.
package dtw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFin
  } dtw_state_e;

  localparam logic [1:0] SelHold = 2'b00;
  localparam logic [1:0] SelExt  = 2'b01;
  localparam logic [1:0] SelNbr  = 2'b10;
  localparam logic [1:0] SelClr  = 2'b11;

endpackage

// File: rtl/dtw_ctrl.sv
// Tile sequencer for an N_PE-wide DTW systolic array: loads T rows per tile, then streams R.
// Optional busy/stall performance counters are enabled with DTW_CTRL_PERF_EN.
module dtw_ctrl
  import dtw_pkg::*;
#(
  parameter int unsigned N_PE = 6,
  parameter int unsigned DW   = 30,
  parameter int unsigned LW   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LW-1:0]       t_len,
  input  logic [LW-1:0]       r_len,
  input  logic [DW-1:0]       t_data,
  input  logic                t_valid,
  output logic                t_ready,
  input  logic [DW-1:0]       r_data,
  input  logic                r_valid,
  output logic                r_ready,
  output logic                sa_ena,
  output logic [DW-1:0]       sa_T,
  output logic [DW-1:0]       sa_R,
  output logic [2*N_PE-1:0]   sa_tsrc,
  output logic [2*N_PE-1:0]   sa_rsrc,
  output logic [N_PE-1:0]     pe_active,
  output logic [LW-1:0]       row_base,
  output logic [LW-1:0]       col_idx,
  output logic                busy,
  output logic                done
`ifdef DTW_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_cyc,
  output logic [31:0]         perf_stall
`endif
);

  // One extra index bit so row_base + N_PE and the skew-tail count never wrap.
  localparam int unsigned IW = LW + 1;
  localparam logic [IW-1:0] NPe = IW'(N_PE);

  dtw_state_e    state_q;
  logic [IW-1:0] t_len_q, r_len_q, row_base_q, slot_q, c_q;
  logic [IW-1:0] slot_row, c_last, next_base;
  logic          slot_real, in_body;

  always_comb begin
    slot_row  = row_base_q + slot_q;
    slot_real = slot_row < t_len_q;
    c_last    = r_len_q + NPe - IW'(2);
    in_body   = c_q < r_len_q;
    next_base = row_base_q + NPe;
  end

  always_comb begin
    t_ready   = 1'b0;
    r_ready   = 1'b0;
    sa_ena    = 1'b0;
    sa_T      = '0;
    sa_R      = '0;
    sa_tsrc   = '0;
    sa_rsrc   = '0;
    pe_active = '0;
    col_idx   = '0;
    unique case (state_q)
      StLoad: begin
        for (int k = 0; k < int'(N_PE); k++) begin
          if (slot_q == IW'(k)) begin
            sa_tsrc[2*(int'(N_PE)-1-k) +: 2] = slot_real ? (t_valid ? SelExt : SelHold) : SelClr;
          end
        end
        if (slot_real) begin
          t_ready = 1'b1;
          sa_ena  = t_valid;
          sa_T    = t_valid ? t_data : '0;
        end else begin
          sa_ena = 1'b1;
        end
      end
      StRun: begin
        for (int k = 0; k < int'(N_PE); k++) begin
          sa_rsrc[2*(int'(N_PE)-1-k) +: 2] = (k == 0) ? (in_body ? SelExt : SelClr) : SelNbr;
        end
        if (in_body) begin
          r_ready = 1'b1;
          col_idx = c_q[LW-1:0];
          sa_ena  = r_valid;
          sa_R    = r_data;
        end else begin
          sa_ena = 1'b1;
        end
        // PE k sees column c-k of its row; inactive before the wavefront, after it, or on padding.
        for (int k = 0; k < int'(N_PE); k++) begin
          pe_active[k] = sa_ena && (c_q >= IW'(k)) && (c_q < IW'(k) + r_len_q) &&
                         ((row_base_q + IW'(k)) < t_len_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      t_len_q    <= '0;
      r_len_q    <= '0;
      row_base_q <= '0;
      slot_q     <= '0;
      c_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            t_len_q    <= {1'b0, t_len};
            r_len_q    <= {1'b0, r_len};
            row_base_q <= '0;
            slot_q     <= '0;
            c_q        <= '0;
            state_q    <= ((t_len == '0) || (r_len == '0)) ? StFin : StLoad;
          end
        end
        StLoad: begin
          if (sa_ena) begin
            if (slot_q == NPe - IW'(1)) begin
              slot_q  <= '0;
              c_q     <= '0;
              state_q <= StRun;
            end else begin
              slot_q <= slot_q + IW'(1);
            end
          end
        end
        StRun: begin
          if (sa_ena) begin
            if (c_q == c_last) begin
              c_q        <= '0;
              row_base_q <= next_base;
              state_q    <= (next_base < t_len_q) ? StLoad : StFin;
            end else begin
              c_q <= c_q + IW'(1);
            end
          end
        end
        StFin: begin
          row_base_q <= '0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign row_base = row_base_q[LW-1:0];
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin);

`ifdef DTW_CTRL_PERF_EN
  logic [31:0] perf_cyc_q, perf_stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        perf_cyc_q   <= '0;
        perf_stall_q <= '0;
      end
    end else begin
      if (perf_cyc_q != '1) perf_cyc_q <= perf_cyc_q + 32'd1;
      if ((state_q == StRun) && !sa_ena && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_cyc   = perf_cyc_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule
